// File: rtl/demux_1to2_buf.sv
// Registered 1:2 demultiplexer: each output owns a small valid/ready FIFO.
// Define DEMUX_COUNT_EN to add per-output 16-bit pop counters (Out0Count/Out1Count).
module demux_1to2_buf #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] InData,
  input  logic             Selector,
  output logic             Out0Valid,
  input  logic             Out0Ready,
  output logic [WIDTH-1:0] Out0Data,
  output logic             Out1Valid,
  input  logic             Out1Ready,
  output logic [WIDTH-1:0] Out1Data
`ifdef DEMUX_COUNT_EN
  ,
  output logic [15:0]      Out0Count,
  output logic [15:0]      Out1Count
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem    [2][DEPTH];
  logic [AW-1:0]    wr_ptr [2];
  logic [AW-1:0]    rd_ptr [2];
  logic [AW:0]      count  [2];

  logic [1:0] full;
  logic [1:0] valid;
  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] ready;

  assign ready = {Out1Ready, Out0Ready};

  // NOTE: every signal gets a value on every path through always_comb, so no latch is inferred.
  always_comb begin
    full  = '0;
    valid = '0;
    push  = '0;
    pop   = '0;
    for (int s = 0; s < 2; s++) begin
      full[s]  = (count[s] == (AW+1)'(DEPTH));
      valid[s] = (count[s] != '0);
      // A full side refuses the word even if it pops this cycle.
      push[s]  = InValid && !full[s] && (Selector == 1'(s));
      pop[s]   = valid[s] && ready[s];
    end
  end

  assign InReady = !full[Selector];

  // NOTE: sequential state uses non-blocking assignments so every update reads pre-edge values.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int s = 0; s < 2; s++) begin
        wr_ptr[s] <= '0;
        rd_ptr[s] <= '0;
        count[s]  <= '0;
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (push[s]) wr_ptr[s] <= wr_ptr[s] + 1'b1;
        if (pop[s])  rd_ptr[s] <= rd_ptr[s] + 1'b1;
        case ({push[s], pop[s]})
          2'b10:   count[s] <= count[s] + 1'b1;
          2'b01:   count[s] <= count[s] - 1'b1;
          default: count[s] <= count[s];
        endcase
      end
    end
  end

  // NOTE: storage is deliberately not reset; an empty side forces its data output to zero instead.
  always_ff @(posedge Clock) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s]) mem[s][wr_ptr[s]] <= InData;
    end
  end

  assign Out0Valid = valid[0];
  assign Out1Valid = valid[1];
  assign Out0Data  = valid[0] ? mem[0][rd_ptr[0]] : '0;
  assign Out1Data  = valid[1] ? mem[1][rd_ptr[1]] : '0;

`ifdef DEMUX_COUNT_EN
  logic [15:0] pop_count [2];

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      pop_count[0] <= '0;
      pop_count[1] <= '0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (pop[s]) pop_count[s] <= pop_count[s] + 16'd1;
      end
    end
  end

  assign Out0Count = pop_count[0];
  assign Out1Count = pop_count[1];
`endif

endmodule

// File: tb/tb_demux_1to2_buf.sv
// Scoreboard bench for demux_1to2_buf: stimulus pushes expected words, a monitor pops on handshakes.
module tb_demux_1to2_buf;
  localparam int WIDTH = 16;
  localparam int DEPTH = 2;

  logic             Clock = 1'b0;
  logic             Reset_n;
  logic             InValid;
  logic             InReady;
  logic [WIDTH-1:0] InData;
  logic             Selector;
  logic             Out0Valid;
  logic             Out0Ready;
  logic [WIDTH-1:0] Out0Data;
  logic             Out1Valid;
  logic             Out1Ready;
  logic [WIDTH-1:0] Out1Data;
`ifdef DEMUX_COUNT_EN
  logic [15:0]      Out0Count;
  logic [15:0]      Out1Count;
`endif

  demux_1to2_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .InValid   (InValid),
    .InReady   (InReady),
    .InData    (InData),
    .Selector  (Selector),
    .Out0Valid (Out0Valid),
    .Out0Ready (Out0Ready),
    .Out0Data  (Out0Data),
    .Out1Valid (Out1Valid),
    .Out1Ready (Out1Ready),
    .Out1Data  (Out1Data)
`ifdef DEMUX_COUNT_EN
    ,
    .Out0Count (Out0Count),
    .Out1Count (Out1Count)
`endif
  );

  always #5 Clock = ~Clock;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] exp_q0[$];
  logic [WIDTH-1:0] exp_q1[$];
  int               occ[2];
  logic [15:0]      pops[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a handshake seen at the falling edge completes at the next rising edge.
  initial begin
    forever begin
      @(negedge Clock);
      if (Reset_n === 1'b1) begin
        if (Out0Valid === 1'b1 && Out0Ready === 1'b1) begin
          if (exp_q0.size() == 0) check("out0_unexpected", Out0Data, 32'hDEAD_0000);
          else check("out0_pop", Out0Data, exp_q0.pop_front());
        end
        if (Out1Valid === 1'b1 && Out1Ready === 1'b1) begin
          if (exp_q1.size() == 0) check("out1_unexpected", Out1Data, 32'hDEAD_0001);
          else check("out1_pop", Out1Data, exp_q1.pop_front());
        end
      end
    end
  end

  // One clock of stimulus; the occupancy model predicts ready/valid from pre-edge state.
  task automatic step(input logic iv, input logic [15:0] d, input logic sel,
                      input logic r0, input logic r1);
    logic exp_rdy;
    logic acc;
    InValid = iv; InData = d; Selector = sel; Out0Ready = r0; Out1Ready = r1;
    #3;
    check("out0_valid", Out0Valid, occ[0] > 0);
    check("out1_valid", Out1Valid, occ[1] > 0);
    if (occ[0] > 0) check("out0_head", Out0Data, exp_q0[0]);
    else            check("out0_zero", Out0Data, 0);
    if (occ[1] > 0) check("out1_head", Out1Data, exp_q1[0]);
    else            check("out1_zero", Out1Data, 0);
    acc = 1'b0;
    if (!$isunknown(sel)) begin
      exp_rdy = occ[sel] < DEPTH;
      check("in_ready", InReady, exp_rdy);
      acc = iv && exp_rdy;
    end
    if (occ[0] > 0 && r0) begin occ[0]--; pops[0]++; end
    if (occ[1] > 0 && r1) begin occ[1]--; pops[1]++; end
    if (acc) begin
      occ[sel]++;
      if (sel) exp_q1.push_back(d);
      else     exp_q0.push_back(d);
    end
    @(posedge Clock);
    #1;
  endtask

  initial begin
    occ[0] = 0; occ[1] = 0; pops[0] = '0; pops[1] = '0;
    Reset_n = 1'b0;
    InValid = 1'b0; InData = '0; Selector = 1'b0; Out0Ready = 1'b0; Out1Ready = 1'b0;
    #2;
    check("rst_out0_valid", Out0Valid, 0);
    check("rst_out1_valid", Out1Valid, 0);
    check("rst_in_ready",   InReady,   1);
    @(posedge Clock);
    #1;
    Reset_n = 1'b1;

    // First word lands on output 0 one cycle after acceptance.
    step(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);

    // Fill output 1; ready depends only on the selected side.
    step(1'b1, 16'hAAAA, 1'b1, 1'b0, 1'b0);
    step(1'b1, 16'hBBBB, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    // Full side pops while offered a word: no push-through.
    step(1'b1, 16'hCCCC, 1'b1, 1'b0, 1'b1);
    step(1'b1, 16'hDDDD, 1'b1, 1'b0, 1'b0);

    // Output 1 full and stalled; output 0 still accepts.
    step(1'b1, 16'h0005, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

    // Simultaneous push and pop on output 0 across pointer wrap.
    step(1'b1, 16'h00FF, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);

    // Drain output 1 in order, then both empty; X selector while idle is harmless.
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'bx, 1'b1, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

`ifdef DEMUX_COUNT_EN
    check("count0", Out0Count, pops[0]);
    check("count1", Out1Count, pops[1]);
`endif

    // Fill both sides, then reset mid-cycle.
    step(1'b1, 16'h1111, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h2222, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h3333, 1'b1, 1'b0, 1'b0);
    step(1'b1, 16'h4444, 1'b1, 1'b0, 1'b0);
    check("filled_ready0", InReady, 0);
    InValid = 1'b0;
    #2;
    Reset_n = 1'b0;
    #1;
    check("midrst_out0_valid", Out0Valid, 0);
    check("midrst_out1_valid", Out1Valid, 0);
    check("midrst_out0_data",  Out0Data,  0);
    check("midrst_out1_data",  Out1Data,  0);
    exp_q0.delete(); exp_q1.delete();
    occ[0] = 0; occ[1] = 0; pops[0] = '0; pops[1] = '0;
    @(posedge Clock);
    #1;
    InValid = 1'b1; Selector = 1'b1;
    #1;
    check("midrst_in_ready", InReady, 1);
    @(posedge Clock);
    #1;
    check("midrst_nothing_taken", Out1Valid, 0);
    Reset_n = 1'b1;

    // First push after release appears one cycle later.
    step(1'b1, 16'h5555, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h6666, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h7777, 1'b0, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);

`ifdef DEMUX_COUNT_EN
    check("count0_after_rst", Out0Count, pops[0]);
    check("count1_after_rst", Out1Count, pops[1]);
`endif

    check("q0_drained", exp_q0.size(), 0);
    check("q1_drained", exp_q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
